// File: rtl/hvac_actuator_seq_pkg.sv
// Shared types and default timing values for the HVAC actuator sequencer.
// The state encoding is visible on the state port, so the values are fixed.
package hvac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HEAT    = 3'd1,
    ST_COOL    = 3'd2,
    ST_RUNON   = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_t;

  localparam int unsigned DEF_MIN_ON  = 8;
  localparam int unsigned DEF_RUNON   = 4;
  localparam int unsigned DEF_MIN_OFF = 6;
  localparam int unsigned DEF_TW      = 8;

  typedef struct packed {
    logic heater_on;
    logic compressor_on;
    logic fan_on;
  } drive_t;

  // Moore decode of the actuator drives; unknown encodings drive nothing.
  function automatic drive_t decode_drive(input state_t s);
    drive_t d;
    d = '0;
    case (s)
      ST_HEAT:  begin d.heater_on     = 1'b1; d.fan_on = 1'b1; end
      ST_COOL:  begin d.compressor_on = 1'b1; d.fan_on = 1'b1; end
      ST_RUNON: d.fan_on = 1'b1;
      default:  d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/hvac_actuator_seq_if.sv
// Demand inputs and actuator/status outputs of the sequencer as one bundle.
// master = temperature monitor side, slave = the sequencer itself.
interface hvac_actuator_seq_if;
  logic       heat_req;
  logic       cool_req;
  logic       heater_on;
  logic       compressor_on;
  logic       fan_on;
  logic       conflict;
  logic [2:0] state;

  modport master (
    output heat_req, cool_req,
    input  heater_on, compressor_on, fan_on, conflict, state
  );

  modport slave (
    input  heat_req, cool_req,
    output heater_on, compressor_on, fan_on, conflict, state
  );
endinterface

// File: rtl/hvac_actuator_seq_dwell_timer.sv
// Dwell counter: clears on clr, otherwise counts up and holds at limit-1.
// done flags that the hold value has been reached.
module hvac_dwell_timer #(
  parameter int unsigned TW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [TW-1:0] limit,
  output logic          done
);

  localparam logic [TW-1:0] ONE = TW'(1);

  logic [TW-1:0] count;
  logic [TW-1:0] last;

  assign last = limit - ONE;
  assign done = (count == last);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (count != last) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/hvac_actuator_seq.sv
// HVAC actuator sequencer: minimum on-time, fan run-on and off lockout
// around heater/compressor demands, with registered Moore outputs.
module hvac_actuator_seq
  import hvac_pkg::*;
#(
  parameter int unsigned MIN_ON  = DEF_MIN_ON,
  parameter int unsigned RUNON   = DEF_RUNON,
  parameter int unsigned MIN_OFF = DEF_MIN_OFF,
  parameter int unsigned TW      = DEF_TW
) (
  input  logic            clk,
  input  logic            rst,
  hvac_actuator_seq_if.slave bus
);

  localparam logic [TW-1:0] MIN_ON_T  = TW'(MIN_ON);
  localparam logic [TW-1:0] RUNON_T   = TW'(RUNON);
  localparam logic [TW-1:0] MIN_OFF_T = TW'(MIN_OFF);
  localparam logic [TW-1:0] IDLE_T    = TW'(1);

  state_t        state_q;
  state_t        next_state;
  logic [TW-1:0] limit;
  logic          timer_clr;
  logic          timer_done;
  logic          conflict_d;
  drive_t        drive_q;
  logic          conflict_q;
  logic          heat;
  logic          cool;

  assign heat = bus.heat_req;
  assign cool = bus.cool_req;

  hvac_dwell_timer #(.TW(TW)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (timer_clr),
    .limit (limit),
    .done  (timer_done)
  );

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    next_state = ST_IDLE;
    limit      = IDLE_T;
    conflict_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (heat && !cool)      next_state = ST_HEAT;
        else if (cool && !heat) next_state = ST_COOL;
        else begin
          next_state = ST_IDLE;
          conflict_d = heat && cool;
        end
      end
      ST_HEAT: begin
        limit      = MIN_ON_T;
        next_state = (timer_done && (!heat || cool)) ? ST_RUNON : ST_HEAT;
      end
      ST_COOL: begin
        limit      = MIN_ON_T;
        next_state = (timer_done && (!cool || heat)) ? ST_RUNON : ST_COOL;
      end
      ST_RUNON: begin
        limit      = RUNON_T;
        next_state = timer_done ? ST_LOCKOUT : ST_RUNON;
      end
      ST_LOCKOUT: begin
        limit      = MIN_OFF_T;
        next_state = timer_done ? ST_IDLE : ST_LOCKOUT;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  assign timer_clr = (next_state != state_q);

  // Outputs are decoded from next_state so the flops line up with state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      drive_q    <= '0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= next_state;
      drive_q    <= decode_drive(next_state);
      conflict_q <= conflict_d;
    end
  end

  assign bus.heater_on     = drive_q.heater_on;
  assign bus.compressor_on = drive_q.compressor_on;
  assign bus.fan_on        = drive_q.fan_on;
  assign bus.conflict      = conflict_q;
  assign bus.state         = state_q;

endmodule

// File: tb/tb_hvac_actuator_seq.sv
// Directed bench for hvac_actuator_seq with default parameters.
// Observed word is {heater_on, compressor_on, fan_on, conflict, state}.
module tb_hvac_actuator_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  hvac_actuator_seq_if bus ();

  hvac_actuator_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] E_IDLE  = 7'b000_0_000;
  localparam logic [6:0] E_CONF  = 7'b000_1_000;
  localparam logic [6:0] E_HEAT  = 7'b101_0_001;
  localparam logic [6:0] E_COOL  = 7'b011_0_010;
  localparam logic [6:0] E_RUNON = 7'b001_0_011;
  localparam logic [6:0] E_LOCK  = 7'b000_0_100;

  function automatic logic [6:0] observed();
    return {bus.heater_on, bus.compressor_on, bus.fan_on, bus.conflict, bus.state};
  endfunction

  task automatic check(input string tag, input logic [6:0] exp);
    logic [6:0] obs;
    obs = observed();
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // n edges, checking the outputs after each one.
  task automatic run_check(input string tag, input logic [6:0] exp, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check(tag, exp);
    end
  endtask

  initial begin
    bus.heat_req = 1'b0;
    bus.cool_req = 1'b0;

    // Reset state
    tick();
    tick();
    check("reset_hold", E_IDLE);
    rst = 1'b0;
    run_check("idle_no_demand", E_IDLE, 1);

    // 1-cycle heat pulse: 8 heat, 4 run-on, 6 lockout, idle
    bus.heat_req = 1'b1;
    tick();
    bus.heat_req = 1'b0;
    check("pulse_heat_first", E_HEAT);
    run_check("pulse_heat", E_HEAT, 7);
    run_check("pulse_runon", E_RUNON, 4);
    run_check("pulse_lockout", E_LOCK, 6);
    run_check("pulse_idle", E_IDLE, 1);

    // Both demands in IDLE
    bus.heat_req = 1'b1;
    bus.cool_req = 1'b1;
    run_check("conflict_set", E_CONF, 1);
    bus.heat_req = 1'b0;
    bus.cool_req = 1'b0;
    run_check("conflict_clear", E_IDLE, 1);

    // cool_req sampled on 20 edges: 20 cycles of compressor
    bus.cool_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 19) bus.cool_req = 1'b0;
      check("held_cool", E_COOL);
    end
    run_check("held_runon", E_RUNON, 4);
    run_check("held_lockout", E_LOCK, 6);
    run_check("held_idle", E_IDLE, 1);

    // cool_req rises at HEAT timer=3; heat still completes its minimum on-time
    bus.heat_req = 1'b1;
    run_check("switch_heat_a", E_HEAT, 4);
    bus.heat_req = 1'b0;
    bus.cool_req = 1'b1;
    run_check("switch_heat_b", E_HEAT, 4);
    run_check("switch_runon", E_RUNON, 4);
    run_check("switch_lockout", E_LOCK, 6);
    run_check("switch_idle", E_IDLE, 1);
    run_check("switch_cool", E_COOL, 1);

    // Asynchronous reset mid-COOL
    run_check("abort_cool", E_COOL, 2);
    rst = 1'b1;
    #1;
    check("abort_async", E_IDLE);
    bus.cool_req = 1'b0;
    bus.heat_req = 1'b1;
    tick();
    check("abort_hold", E_IDLE);
    rst = 1'b0;

    // First edge after reset evaluates IDLE arbitration
    tick();
    bus.heat_req = 1'b0;
    check("post_reset_heat", E_HEAT);
    run_check("post_reset_heat_b", E_HEAT, 7);

    // heat_req toggling in RUNON/LOCKOUT is ignored
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.heat_req = ~bus.heat_req;
      check("toggle_runon", E_RUNON);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      bus.heat_req = ~bus.heat_req;
      check("toggle_lockout", E_LOCK);
    end
    bus.heat_req = 1'b1;
    run_check("toggle_idle", E_IDLE, 1);
    run_check("toggle_heat", E_HEAT, 1);
    bus.heat_req = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hvac_actuator_seq.md
HVAC_ACTUATOR_SEQ -- requirements
Module: hvac_actuator_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter MIN_ON, default 8, SHALL set the minimum cycles the heater or compressor stays on.
REQ-003 Parameter RUNON, default 4, SHALL set the fan run-on cycles after the heater or compressor switches off.
REQ-004 Parameter MIN_OFF, default 6, SHALL set the lockout cycles with all outputs off before a new demand is accepted.
REQ-005 Parameter TW, default 8, SHALL set the timer width; all three timing parameters SHALL be in the range 1..2^TW-1.
REQ-006 Port clk, input, 1 bit: SHALL be the system clock; all state updates on its rising edge.
REQ-007 Port rst, input, 1 bit: SHALL be the asynchronous, active-high reset.
REQ-008 Port heat_req, input, 1 bit: SHALL be the heating demand from the temperature monitor.
REQ-009 Port cool_req, input, 1 bit: SHALL be the cooling demand from the temperature monitor.
REQ-010 Port heater_on, output, 1 bit: SHALL drive the heater element.
REQ-011 Port compressor_on, output, 1 bit: SHALL drive the cooling compressor.
REQ-012 Port fan_on, output, 1 bit: SHALL drive the circulation fan.
REQ-013 Port conflict, output, 1 bit: SHALL flag that both demands were seen together in IDLE.
REQ-014 Port state, output, 3 bits: SHALL expose the current FSM state encoding.

Function
REQ-015 The FSM SHALL have states IDLE=0, HEAT=1, COOL=2, RUNON=3 and LOCKOUT=4.
REQ-016 All outputs SHALL be registered Moore decodes of the state; state and timer update on the rising edge of clk.
REQ-017 Output decode SHALL be:
- HEAT: heater_on=1, fan_on=1
- COOL: compressor_on=1, fan_on=1
- RUNON: fan_on=1 only
- IDLE and LOCKOUT: all drive outputs 0
REQ-018 In IDLE, demand arbitration SHALL be:
- heat_req=1 and cool_req=0: go to HEAT
- cool_req=1 and heat_req=0: go to COOL
- both 1: stay in IDLE and set conflict=1 on the next edge
- otherwise: conflict=0
REQ-019 A dwell timer SHALL clear to 0 on every state change.
REQ-020 Within a state, the timer SHALL increment each cycle and saturate at that state's limit minus 1.
REQ-021 HEAT SHALL exit to RUNON only when timer==MIN_ON-1 and (heat_req==0 or cool_req==1); COOL SHALL mirror this with cool_req/heat_req swapped.
REQ-022 Consequently heater_on or compressor_on SHALL stay high for at least MIN_ON consecutive cycles.
REQ-023 RUNON SHALL go to LOCKOUT when timer==RUNON-1, giving exactly RUNON cycles of fan-only operation.
REQ-024 LOCKOUT SHALL go to IDLE when timer==MIN_OFF-1; demands SHALL be ignored in RUNON and LOCKOUT.
REQ-025 heater_on and compressor_on SHALL never be high in the same cycle, and SHALL be separated by at least RUNON+MIN_OFF+1 cycles.
REQ-026 Illegal state encodings 5..7 SHALL return to IDLE on the next edge with all outputs 0.
REQ-027 Latency from a demand sampled in IDLE to heater_on/compressor_on high SHALL be exactly 1 cycle.

Reset
REQ-028 While rst=1, without waiting for a clock edge, the block SHALL set state=IDLE, timer=0 and all outputs to 0.
REQ-029 Reset asserted in any state, including mid-HEAT or mid-COOL, SHALL abort the sequence with no run-on or lockout.
REQ-030 After rst deasserts, the first edge SHALL evaluate the IDLE arbitration.

Structure
REQ-031 Shared package hvac_pkg SHALL hold the state type/encodings and the default MIN_ON, RUNON, MIN_OFF and TW values.
REQ-032 Sub-module hvac_dwell_timer SHALL implement the clear/increment/saturate counter, with inputs clr and limit and output done.

Verification
REQ-033 A 1-cycle heat_req pulse in IDLE SHALL produce heater_on+fan_on for 8 cycles, then fan_on only for 4 cycles, then all 0 for 6 cycles, then state=0.
REQ-034 cool_req held for 20 cycles SHALL hold compressor_on for 20 cycles, then complete run-on and lockout as in REQ-033.
REQ-035 heat_req=cool_req=1 in IDLE SHALL give conflict=1 on the next edge, state=0 and all drive outputs 0.
REQ-036 cool_req rising at HEAT timer=3 SHALL keep heater_on until 8 cycles, then RUNON 4, LOCKOUT 6, then COOL with compressor_on 1 cycle later and no overlap.
REQ-037 rst pulsed mid-COOL SHALL drop compressor_on and fan_on before the next clk edge, with state=0.
REQ-038 heat_req toggling during RUNON/LOCKOUT SHALL be ignored; if heat_req=1 at the IDLE edge, heater_on SHALL rise 1 cycle later.
